spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 241 ++++++++++++++++++++++++
 tb/tb_spi_slave.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave -- SPI mode-3 style slave (sck idles high; sample on rise,
// shift on fall) that oversamples the SPI pins with the system clock.
//
// Ports:
//   clk      system clock, all flops on its rising edge
//   rst      asynchronous active-high reset
//   sck      SPI clock from master (idle high)
//   ss_n     slave select, active low
//   mosi     serial data from master
//   mlb      bit order: 0 = LSB first, 1 = MSB first (latched at frame start)
//   tdat     byte to transmit, captured at frame start and each byte boundary
//   rd_ack   host acknowledge of rdata (only used with SPI_SLAVE_OVERRUN_EN)
//   miso     serial data to master (1 while idle)
//   miso_oe  miso output enable, active while selected
//   rdata    last complete received byte, valid with done and held after
//   done     one-clk pulse per completed byte
//   busy     high while shifting a byte (XFER)
//   overrun  sticky "byte completed before previous one was acknowledged"
//
// Handshake: done is a one-cycle valid with no ready; rdata is valid in the
// done cycle and stays stable until the next done. With the overrun option,
// rd_ack is the host's consume strobe for the most recent byte.
//
// Optional feature: define SPI_SLAVE_OVERRUN_EN to build the unread/overrun
// tracking. Without it rd_ack is ignored and overrun is tied low.
`timescale 1ns/1ps

module spi_slave (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       ss_n,
  input  logic       mosi,
  input  logic       mlb,
  input  logic [7:0] tdat,
  input  logic       rd_ack,
  output logic       miso,
  output logic       miso_oe,
  output logic [7:0] rdata,
  output logic       done,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Synchronizers plus one "previous" stage each for sck and ss_n.
  logic sck_s1_q, sck_s2_q, sck_p_q;
  logic ss_s1_q,  ss_s2_q,  ss_p_q;
  logic mosi_s1_q, mosi_s2_q;

  // After reset the ss_n chain comes out of its preset-high state; if the pin
  // is already low that looks like a fall. armed_q only goes high once the
  // chain has flushed and a genuine high level on ss_n has been seen.
  logic [1:0] flush_q, flush_d;
  logic       armed_q, armed_d;

  state_t     state_q, state_d;
  logic       mlb_q, mlb_d;
  logic [7:0] treg_q, treg_d;
  logic [7:0] rreg_q, rreg_d;
  logic [3:0] nbit_q, nbit_d;
  logic       miso_q, miso_d;
  logic [7:0] rdata_q, rdata_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;

  logic sck_rise, sck_fall, ss_fall, ss_rise;

  function automatic logic first_bit(input logic msb_first, input logic [7:0] b);
    return msb_first ? b[7] : b[0];
  endfunction

  assign sck_rise = sck_s2_q & ~sck_p_q;
  assign sck_fall = ~sck_s2_q & sck_p_q;
  assign ss_fall  = ~ss_s2_q & ss_p_q & armed_q;
  assign ss_rise  = ss_s2_q & ~ss_p_q;

  always_comb begin
    flush_d = (flush_q == 2'd3) ? flush_q : flush_q + 2'd1;
    armed_d = armed_q | ((flush_q == 2'd3) & ss_s2_q);

    state_d = state_q;
    mlb_d   = mlb_q;
    treg_d  = treg_q;
    rreg_d  = rreg_q;
    nbit_d  = nbit_q;
    miso_d  = miso_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b1;
        if (ss_fall) begin
          state_d = XFER;
          mlb_d   = mlb;
          treg_d  = tdat;
          miso_d  = first_bit(mlb, tdat);
          nbit_d  = 4'd0;
        end
      end

      XFER: begin
        if (ss_rise) begin
          // Deselect before the 8th rise: drop the partial byte.
          state_d = IDLE;
          miso_d  = 1'b1;
          nbit_d  = 4'd0;
        end else if (sck_rise) begin
          rreg_d = mlb_q ? {rreg_q[6:0], mosi_s2_q} : {mosi_s2_q, rreg_q[7:1]};
          nbit_d = nbit_q + 4'd1;
          if (nbit_q == 4'd7) begin
            // Publish on the transition so rdata and done appear together.
            state_d = DONE;
            rdata_d = rreg_d;
            done_d  = 1'b1;
          end
        end else if (sck_fall && (nbit_q != 4'd0) && (nbit_q < 4'd8)) begin
          // The fall before the first rise must not disturb the first bit.
          if (mlb_q) begin
            treg_d = {treg_q[6:0], 1'b1};
            miso_d = treg_q[6];
          end else begin
            treg_d = {1'b1, treg_q[7:1]};
            miso_d = treg_q[1];
          end
        end
      end

      DONE: begin
        nbit_d = 4'd0;
        treg_d = tdat;
        if (!ss_s2_q) begin
          state_d = XFER;
          miso_d  = first_bit(mlb_q, tdat);
        end else begin
          state_d = IDLE;
          miso_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        miso_d  = 1'b1;
      end
    endcase

    busy_d = (state_d == XFER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_s1_q  <= 1'b1;
      sck_s2_q  <= 1'b1;
      sck_p_q   <= 1'b1;
      ss_s1_q   <= 1'b1;
      ss_s2_q   <= 1'b1;
      ss_p_q    <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      flush_q   <= 2'd0;
      armed_q   <= 1'b0;
      state_q   <= IDLE;
      mlb_q     <= 1'b0;
      treg_q    <= 8'hFF;
      rreg_q    <= 8'hFF;
      nbit_q    <= 4'd0;
      miso_q    <= 1'b1;
      rdata_q   <= 8'h00;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sck_s1_q  <= sck;
      sck_s2_q  <= sck_s1_q;
      sck_p_q   <= sck_s2_q;
      ss_s1_q   <= ss_n;
      ss_s2_q   <= ss_s1_q;
      ss_p_q    <= ss_s2_q;
      mosi_s1_q <= mosi;
      mosi_s2_q <= mosi_s1_q;
      flush_q   <= flush_d;
      armed_q   <= armed_d;
      state_q   <= state_d;
      mlb_q     <= mlb_d;
      treg_q    <= treg_d;
      rreg_q    <= rreg_d;
      nbit_q    <= nbit_d;
      miso_q    <= miso_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign miso    = miso_q;
  assign miso_oe = ~ss_s2_q & armed_q;
  assign rdata   = rdata_q;
  assign done    = done_q;
  assign busy    = busy_q;

`ifdef SPI_SLAVE_OVERRUN_EN
  logic unread_q, unread_d;
  logic overrun_q, overrun_d;

  // done wins over rd_ack in the same cycle: the new byte is still unread.
  always_comb begin
    unread_d  = unread_q;
    overrun_d = overrun_q;
    if (rd_ack) begin
      unread_d  = 1'b0;
      overrun_d = 1'b0;
    end
    if (done_q) begin
      unread_d = 1'b1;
      if (unread_q) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unread_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      unread_q  <= unread_d;
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  logic unused_rd_ack;
  assign unused_rd_ack = rd_ack;
  assign overrun       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps

module tb_spi_slave;

  localparam int HALF = 5;  // sck half period in clk cycles

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b1;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       mlb = 1'b0;
  logic [7:0] tdat = 8'hFF;
  logic       rd_ack = 1'b0;
  logic       miso, miso_oe, done, busy, overrun;
  logic [7:0] rdata;

  always #5 clk = ~clk;

  spi_slave dut (
    .clk     (clk),
    .rst     (rst),
    .sck     (sck),
    .ss_n    (ss_n),
    .mosi    (mosi),
    .mlb     (mlb),
    .tdat    (tdat),
    .rd_ack  (rd_ack),
    .miso    (miso),
    .miso_oe (miso_oe),
    .rdata   (rdata),
    .done    (done),
    .busy    (busy),
    .overrun (overrun)
  );

  // ---------------- scoreboard state ----------------
  int         n_vec = 0;
  int         n_err = 0;
  int         done_cnt = 0;
  logic       done_prev = 1'b0;
  logic [7:0] exp_q[$];

`ifdef SPI_SLAVE_OVERRUN_EN
  localparam logic OVR_AFTER_TWO = 1'b1;
`else
  localparam logic OVR_AFTER_TWO = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pops one expected byte and compares rdata.
  always @(negedge clk) begin
    if (rst) begin
      done_prev = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        if (done_prev) begin
          n_vec++;
          n_err++;
          $display("FAIL done_width: got done high 2 cycles expected 1 at %0t", $time);
        end
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got rdata 0x%0h expected no done at %0t", rdata, $time);
        end else begin
          check("rdata_on_done", rdata, exp_q.pop_front());
        end
      end
      done_prev = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master drives mosi on sck fall, samples miso just before sck rise.
  task automatic spi_bits(input logic [7:0] tx, input logic msb, input int nbits,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      sck  = 1'b0;
      mosi = msb ? tx[7-i] : tx[i];
      wait_clk(HALF);
      rx = msb ? {rx[6:0], miso} : {miso, rx[7:1]};
      sck = 1'b1;
      wait_clk(HALF);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_miso"}, miso, 1'b1);
    check({tag, "_miso_oe"}, miso_oe, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  // One select period of nbytes (1 or 2). tdat switches to td1 once the
  // frame has started, so byte 0 returns td0 and byte 1 returns td1.
  task automatic run_frame(input string tag, input logic msb,
                           input logic [7:0] td0, input logic [7:0] td1,
                           input logic [7:0] tx0, input logic [7:0] tx1,
                           input int nbytes);
    logic [7:0] rx;
    int         d0;
    d0   = done_cnt;
    mlb  = msb;
    tdat = td0;
    exp_q.push_back(tx0);
    if (nbytes == 2) exp_q.push_back(tx1);
    ss_n = 1'b0;
    wait_clk(6);
    check({tag, "_busy_sel"}, busy, 1'b1);
    check({tag, "_oe_sel"}, miso_oe, 1'b1);
    tdat = td1;
    spi_bits(tx0, msb, 8, rx);
    check({tag, "_miso_b0"}, rx, td0);
    if (nbytes == 2) begin
      spi_bits(tx1, msb, 8, rx);
      check({tag, "_miso_b1"}, rx, td1);
    end
    wait_clk(HALF);
    ss_n = 1'b1;
    wait_clk(8);
    check({tag, "_done_cnt"}, done_cnt - d0, nbytes);
    check({tag, "_rdata"}, rdata, (nbytes == 2) ? tx1 : tx0);
    check_idle(tag);
  endtask

  task automatic pulse_rd_ack();
    rd_ack = 1'b1;
    wait_clk(1);
    rd_ack = 1'b0;
    wait_clk(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rx;
    int         d0;

    wait_clk(3);
    check("rst_miso", miso, 1'b1);
    check("rst_miso_oe", miso_oe, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    wait_clk(6);

    // MSB first, slave sends A5, master sends 3C.
    run_frame("msb", 1'b1, 8'hA5, 8'hA5, 8'h3C, 8'h00, 1);

    // LSB first, slave sends 81, master sends 96.
    run_frame("lsb", 1'b0, 8'h81, 8'h81, 8'h96, 8'h00, 1);

    // Two-byte stream, tdat switched to F0 for the second byte.
    run_frame("multi", 1'b1, 8'h5A, 8'hF0, 8'h11, 8'h22, 2);

    // Abort after 5 rises: nothing published, then a clean frame.
    d0   = done_cnt;
    mlb  = 1'b1;
    tdat = 8'h33;
    ss_n = 1'b0;
    wait_clk(6);
    spi_bits(8'hFF, 1'b1, 5, rx);
    ss_n = 1'b1;
    wait_clk(8);
    check("abort_done_cnt", done_cnt - d0, 0);
    check("abort_rdata", rdata, 8'h22);
    check_idle("abort");
    run_frame("post_abort", 1'b0, 8'hC3, 8'hC3, 8'h4B, 8'h00, 1);

    // Reset mid-frame with ss_n held low.
    mlb  = 1'b1;
    tdat = 8'h00;
    ss_n = 1'b0;
    wait_clk(6);
    spi_bits(8'hAA, 1'b1, 3, rx);
    rst = 1'b1;
    wait_clk(2);
    check("mid_rst_miso", miso, 1'b1);
    check("mid_rst_oe", miso_oe, 1'b0);
    check("mid_rst_rdata", rdata, 8'h00);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    d0  = done_cnt;
    wait_clk(4);
    spi_bits(8'h5C, 1'b1, 8, rx);
    wait_clk(6);
    check("held_low_busy", busy, 1'b0);
    check("held_low_oe", miso_oe, 1'b0);
    check("held_low_miso", miso, 1'b1);
    check("held_low_done_cnt", done_cnt - d0, 0);
    check("held_low_rdata", rdata, 8'h00);
    ss_n = 1'b1;
    wait_clk(8);
    run_frame("post_rst", 1'b1, 8'hE7, 8'hE7, 8'h7E, 8'h00, 1);

    // Overrun: two bytes without acknowledge, then acknowledge.
    pulse_rd_ack();
    check("ovr_clear_before", overrun, 1'b0);
    run_frame("ovr", 1'b1, 8'h0F, 8'h55, 8'h01, 8'h02, 2);
    check("ovr_after_two", overrun, OVR_AFTER_TWO);
    pulse_rd_ack();
    check("ovr_after_ack", overrun, 1'b0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
